seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed digits (legal range 1..8).
REQ-002 Parameter REFRESH_DIV, default 100000, SHALL set the number of clk cycles each digit is held (legal range >= 2).
REQ-003 Parameter ACTIVE_LOW, default 1, SHALL select polarity: 1 = cathode, dp and anode active-low; 0 = active-high.
REQ-004 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-005 reset  input  1  reset, asynchronous and active-high.
REQ-006 value  input  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i], with digit 0 the rightmost.
REQ-007 dp_in  input  NUM_DIGITS  decimal point request per digit.
REQ-008 digit_en  input  NUM_DIGITS  per-digit enable; a disabled digit is dark.
REQ-009 load  input  1  single-cycle strobe that captures value and dp_in into the shadow register.
REQ-010 lz_blank  input  1  leading-zero suppression enable.
REQ-011 cathode  output  7  segment drive, bit order g,f,e,d,c,b,a (bit6 = g).
REQ-012 dp  output  1  decimal point drive for the current digit.
REQ-013 anode  output  NUM_DIGITS  one-hot digit select.
REQ-014 frame_tick  output  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

Function
REQ-015 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; a terminal count SHALL advance the digit index by 1.
REQ-016 The digit index SHALL wrap from NUM_DIGITS-1 to 0; frame_tick SHALL be high in the cycle after that wrap edge.
REQ-017 A load strobe SHALL write value and dp_in into the shadow register on that edge.
REQ-018 The shadow register SHALL be copied to the active register only on the index wrap to 0, so one frame never mixes data.
REQ-019 If load coincides with the wrap edge, the active register SHALL take the new value and dp_in directly.
REQ-020 Segment encoding SHALL be active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110.
REQ-021 When ACTIVE_LOW=0, the cathode, dp and anode outputs SHALL be the bitwise inverse of the active-low form.
REQ-022 With lz_blank=1, a digit SHALL be blanked (cathode off, dp still honoured) when it and every higher digit in the active register are 0; digit 0 SHALL never be blanked.
REQ-023 A disabled digit SHALL keep its anode inactive and drive cathode and dp off for its whole slot; the scan timing SHALL be unchanged.
REQ-024 cathode, dp and anode SHALL be registered and reflect the current index one clk after the index changes; no combinational path from inputs to outputs.
REQ-025 Exactly one anode bit SHALL be active at any time outside reset, unless the current digit is disabled, in which case none SHALL be active.

Reset
REQ-026 reset high SHALL immediately clear: counter=0, index=0, shadow=0, active=0, frame_tick=0, anode all inactive, cathode and dp off.
REQ-027 On the first rising edge after reset deasserts, the outputs SHALL drive digit 0 showing 0 (cathode 1000000 when ACTIVE_LOW=1).
REQ-028 reset asserted mid-frame SHALL abandon the frame and discard any pending shadow data.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1)
REQ-029 Free run after reset -> anode steps 1110, 1101, 1011, 0111 every 4 cycles; frame_tick pulses once per 16 cycles.
REQ-030 load with value=16'h12AF mid-frame -> current frame is unchanged; next frame shows F=0001110, A=0001000, 2=0100100, 1=1111001 on digits 0..3.
REQ-031 load with value=16'h0050 and lz_blank=1 -> digits 3 and 2 show cathode 1111111, digit 1 shows 0010010, digit 0 shows 1000000.
REQ-032 digit_en=4'b1011 -> digit 2 slot has anode 1111 and cathode 1111111; the other slots are unchanged.
REQ-033 load asserted on the wrap edge with value=16'h8888 and dp_in=4'b0001 -> the same frame shows 0000000 on all digits, with dp=0 only on digit 0.
REQ-034 reset pulsed during the digit 2 slot -> outputs go dark asynchronously, the scan restarts at digit 0, and the display shows 0s.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed hex 7-segment scan driver: refresh divider, digit scan, shadow/active
// double buffering so a frame never mixes old and new data, leading-zero blanking.

module seg_digit_dec (
  input  logic [3:0] i_nib,
  input  logic       i_blank,
  output logic [6:0] o_seg_n
);
  // active-low gfedcba
  always_comb begin
    o_seg_n = 7'b1111111;
    if (!i_blank) begin
      case (i_nib)
        4'h0: o_seg_n = 7'b1000000;
        4'h1: o_seg_n = 7'b1111001;
        4'h2: o_seg_n = 7'b0100100;
        4'h3: o_seg_n = 7'b0110000;
        4'h4: o_seg_n = 7'b0011001;
        4'h5: o_seg_n = 7'b0010010;
        4'h6: o_seg_n = 7'b0000010;
        4'h7: o_seg_n = 7'b1111000;
        4'h8: o_seg_n = 7'b0000000;
        4'h9: o_seg_n = 7'b0010000;
        4'hA: o_seg_n = 7'b0001000;
        4'hB: o_seg_n = 7'b0000011;
        4'hC: o_seg_n = 7'b0100111;
        4'hD: o_seg_n = 7'b0100001;
        4'hE: o_seg_n = 7'b0000110;
        4'hF: o_seg_n = 7'b0001110;
      endcase
    end
  end
endmodule

module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      load,
  input  logic                      lz_blank,
  output logic [6:0]                cathode,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic                      frame_tick
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic INV = (ACTIVE_LOW == 0);

  logic [CW-1:0]                 r_cnt;
  logic [IW-1:0]                 r_idx;
  logic [4*NUM_DIGITS-1:0]       r_sh_val, r_act_val;
  logic [NUM_DIGITS-1:0]         r_sh_dp,  r_act_dp;

  logic                          w_tc, w_last, w_wrap;
  logic [NUM_DIGITS:1]           w_zhi;
  logic [NUM_DIGITS-1:0][6:0]    w_seg_n;
  logic [NUM_DIGITS-1:0]         w_onehot;
  logic                          w_en;
  logic [6:0]                    w_cath_n;
  logic                          w_dp_n;
  logic [NUM_DIGITS-1:0]         w_an_n;

  assign w_tc   = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_last = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_wrap = w_tc & w_last;

  // w_zhi[i]: digits i..NUM_DIGITS-1 of the active register are all zero
  assign w_zhi[NUM_DIGITS] = 1'b1;
  for (genvar gz = 1; gz < NUM_DIGITS; gz++) begin : g_zero
    assign w_zhi[gz] = (r_act_val[4*gz +: 4] == 4'h0) & w_zhi[gz+1];
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
    logic w_blank;
    if (gi == 0) begin : g_d0
      assign w_blank = 1'b0;
    end else begin : g_dn
      assign w_blank = lz_blank & w_zhi[gi];
    end
    seg_digit_dec u_dec (
      .i_nib   (r_act_val[4*gi +: 4]),
      .i_blank (w_blank),
      .o_seg_n (w_seg_n[gi])
    );
  end

  assign w_onehot = NUM_DIGITS'(1) << r_idx;
  assign w_en     = digit_en[r_idx];
  assign w_cath_n = w_en ? w_seg_n[r_idx] : 7'b1111111;
  assign w_dp_n   = ~(w_en & r_act_dp[r_idx]);
  assign w_an_n   = w_en ? ~w_onehot : {NUM_DIGITS{1'b1}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_sh_val   <= '0;
      r_sh_dp    <= '0;
      r_act_val  <= '0;
      r_act_dp   <= '0;
      frame_tick <= 1'b0;
    end else begin
      r_cnt      <= w_tc ? '0 : r_cnt + 1'b1;
      frame_tick <= w_wrap;
      if (w_tc) r_idx <= w_last ? '0 : r_idx + 1'b1;
      if (load) begin
        r_sh_val <= value;
        r_sh_dp  <= dp_in;
      end
      // a load landing on the wrap edge bypasses the shadow into this frame
      if (w_wrap) begin
        r_act_val <= load ? value : r_sh_val;
        r_act_dp  <= load ? dp_in : r_sh_dp;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cathode <= 7'b1111111 ^ {7{INV}};
      dp      <= ~INV;
      anode   <= {NUM_DIGITS{~INV}};
    end else begin
      cathode <= w_cath_n ^ {7{INV}};
      dp      <= w_dp_n ^ INV;
      anode   <= w_an_n ^ {NUM_DIGITS{INV}};
    end
  end
endmodule
